// File: rtl/ping_emulator.sv
// Multi-channel acoustic ping source: periodic tone bursts with per-channel start
// delays, used to stimulate the hydrophone receive chain with known TDOAs.

module ping_lane #(
  parameter int CNT_W   = 16,
  parameter int DLY_W   = 12,
  parameter int BURST_W = 10,
  parameter int HALF_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [CNT_W:0]     t,
  input  logic [DLY_W-1:0]   dly,
  input  logic [BURST_W-1:0] burst,
  input  logic [HALF_W-1:0]  half,
  output logic               tone
);
  // Inputs are the values the controller will hold next cycle, so the tone
  // register lines up with the registered ping_start/t of the same cycle.
  logic [CNT_W:0]  d_x, e_x;
  logic [HALF_W-1:0] ph, ph_n;
  logic lvl, lvl_n, gate;

  assign d_x  = {{(CNT_W+1-DLY_W){1'b0}}, dly};
  assign e_x  = d_x + {{(CNT_W+1-BURST_W){1'b0}}, burst};
  assign gate = run && (t >= d_x) && (t < e_x);

  always_comb begin
    ph_n  = ph;
    lvl_n = lvl;
    if (gate) begin
      if (t == d_x) begin
        ph_n  = '0;
        lvl_n = 1'b1;
      end else if (ph == half) begin
        ph_n  = '0;
        lvl_n = ~lvl;
      end else begin
        ph_n  = ph + HALF_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph   <= '0;
      lvl  <= 1'b0;
      tone <= 1'b0;
    end else begin
      ph   <= ph_n;
      lvl  <= lvl_n;
      tone <= gate & lvl_n;
    end
  end
endmodule

module ping_emulator #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16,
  parameter int DLY_W   = 12,
  parameter int BURST_W = 10,
  parameter int HALF_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      period,
  input  logic [BURST_W-1:0]    burst_len,
  input  logic [HALF_W-1:0]     tone_half,
  input  logic [N_CH*DLY_W-1:0] delay_flat,
  output logic [N_CH-1:0]       ping_out,
  output logic                  ping_start,
  output logic                  busy,
  output logic                  cfg_err
);
  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT} state_t;

  state_t state, state_n;
  logic [CNT_W:0] t, t_n, alen_q, alen_in, per_x;
  logic [CNT_W-1:0] period_q, period_n;
  logic [BURST_W-1:0] burst_q, burst_n;
  logic [HALF_W-1:0] half_q, half_n;
  logic [N_CH-1:0][DLY_W-1:0] dly_in, dly_q, dly_n;
  logic start, run_n, err_n;

  assign dly_in = delay_flat;
  assign per_x  = {1'b0, period_q};

  function automatic logic [CNT_W:0] calc_alen(input logic [N_CH-1:0][DLY_W-1:0] d,
                                               input logic [BURST_W-1:0] b);
    logic [DLY_W-1:0] m;
    logic [CNT_W:0] r;
    m = '0;
    for (int i = 0; i < N_CH; i++)
      if (d[i] > m) m = d[i];
    r = {{(CNT_W+1-DLY_W){1'b0}}, m} + {{(CNT_W+1-BURST_W){1'b0}}, b};
    if (r == '0) r = (CNT_W+1)'(1);
    return r;
  endfunction

  assign alen_q  = calc_alen(dly_q, burst_q);
  assign alen_in = calc_alen(dly_in, burst_len);

  always_comb begin
    state_n = state;
    t_n     = t + (CNT_W+1)'(1);
    start   = 1'b0;
    case (state)
      IDLE:   if (enable) start = 1'b1;
      ACTIVE: if (t == alen_q - (CNT_W+1)'(1)) begin
                if (enable && per_x > alen_q) state_n = WAIT;
                else if (enable)              start   = 1'b1;
                else                          state_n = IDLE;
              end
      WAIT:   if (!enable)                             state_n = IDLE;
              else if (t == per_x - (CNT_W+1)'(1))     start   = 1'b1;
      default: state_n = IDLE;
    endcase
    if (start) begin
      state_n = ACTIVE;
      t_n     = '0;
    end
    if (state_n == IDLE) t_n = '0;
    run_n    = (state_n == ACTIVE);
    // New configuration is captured at every t=0; otherwise hold the latched copy.
    period_n = start ? period     : period_q;
    burst_n  = start ? burst_len  : burst_q;
    half_n   = start ? tone_half  : half_q;
    dly_n    = start ? dly_in     : dly_q;
    err_n    = cfg_err | (start && ((period == '0) || ({1'b0, period} <= alen_in)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      t          <= '0;
      period_q   <= '0;
      burst_q    <= '0;
      half_q     <= '0;
      dly_q      <= '0;
      ping_start <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_n;
      t          <= t_n;
      period_q   <= period_n;
      burst_q    <= burst_n;
      half_q     <= half_n;
      dly_q      <= dly_n;
      ping_start <= start;
      busy       <= (state_n != IDLE);
      cfg_err    <= err_n;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    ping_lane #(.CNT_W(CNT_W), .DLY_W(DLY_W), .BURST_W(BURST_W), .HALF_W(HALF_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run_n),
      .t     (t_n),
      .dly   (dly_n[g]),
      .burst (burst_n),
      .half  (half_n),
      .tone  (ping_out[g])
    );
  end
endmodule

// File: tb/tb_ping_emulator.sv
// Randomized bench for ping_emulator against a ping-cycle level reference model.

module tb_ping_emulator;
  localparam int N_CH = 4, CNT_W = 16, DLY_W = 12, BURST_W = 10, HALF_W = 8;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [CNT_W-1:0] period = '0;
  logic [BURST_W-1:0] burst_len = '0;
  logic [HALF_W-1:0] tone_half = '0;
  logic [N_CH*DLY_W-1:0] delay_flat = '0;
  logic [N_CH-1:0] ping_out;
  logic ping_start, busy, cfg_err;

  ping_emulator #(.N_CH(N_CH), .CNT_W(CNT_W), .DLY_W(DLY_W), .BURST_W(BURST_W), .HALF_W(HALF_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .burst_len(burst_len),
    .tone_half(tone_half), .delay_flat(delay_flat), .ping_out(ping_out),
    .ping_start(ping_start), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, psc = 0;

  // reference model: one ping cycle = max(period, active length) cycles
  bit m_run, m_err;
  int m_t, m_per, m_bl, m_h, m_alen;
  int m_d[N_CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0d time=%0t", tag, got, exp, m_t, $time);
    end
  endtask

  task automatic set_cfg(input int per, input int bl, input int h,
                         input int d0, input int d1, input int d2, input int d3);
    period = CNT_W'(per); burst_len = BURST_W'(bl); tone_half = HALF_W'(h);
    delay_flat = {DLY_W'(d3), DLY_W'(d2), DLY_W'(d1), DLY_W'(d0)};
  endtask

  task automatic m_latch();
    int mx = 0;
    m_run = 1; m_t = 0;
    m_per = int'(period); m_bl = int'(burst_len); m_h = int'(tone_half);
    for (int c = 0; c < N_CH; c++) begin
      m_d[c] = int'(delay_flat[c*DLY_W +: DLY_W]);
      if (m_d[c] > mx) mx = m_d[c];
    end
    m_alen = mx + m_bl;
    if (m_alen == 0) m_alen = 1;
    if (m_per == 0 || m_per <= m_alen) m_err = 1;
  endtask

  task automatic m_step();
    int nt, cyc;
    if (!m_run) begin
      if (enable) m_latch();
    end else begin
      nt  = m_t + 1;
      cyc = (m_per > m_alen) ? m_per : m_alen;
      if (nt >= m_alen && !enable) begin m_run = 0; m_t = 0; end
      else if (nt == cyc) m_latch();
      else m_t = nt;
    end
  endtask

  task automatic m_reset();
    m_run = 0; m_t = 0; m_err = 0;
  endtask

  task automatic check_all();
    logic [N_CH-1:0] exp_po;
    exp_po = '0;
    for (int c = 0; c < N_CH; c++)
      if (m_run && m_t >= m_d[c] && m_t < m_d[c] + m_bl && (((m_t - m_d[c]) / (m_h + 1)) % 2 == 0))
        exp_po[c] = 1'b1;
    chk("ping_out", 32'(ping_out), 32'(exp_po));
    chk("ping_start", 32'(ping_start), 32'(m_run && m_t == 0));
    chk("busy", 32'(busy), 32'(m_run));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  // called at a negedge with inputs already driven; returns at the next negedge
  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
    check_all();
    if (ping_start) psc++;
    @(negedge clk);
  endtask

  task automatic run_until(input int tt, input string tag);
    int n = 0;
    while (!(m_run && m_t == tt) && n < 200) begin cyc(); n++; end
    if (n >= 200) chk({"timeout_", tag}, 32'(n), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    for (int c = 0; c < N_CH; c++) m_d[c] = 0;
    m_per = 0; m_bl = 0; m_h = 0; m_alen = 1;
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // periodic start, period 40
    set_cfg(40, 8, 1, 0, 3, 5, 10);
    enable = 1'b1;
    psc = 0;
    repeat (120) cyc();
    chk("ping_count_40", 32'(psc), 32'd3);

    // overrun: period 12 stretched to 18
    period = 12;
    run_until(0, "ovr");
    psc = 0;
    repeat (54) cyc();
    chk("ping_count_ovr", 32'(psc), 32'd3);
    chk("cfg_err_ovr", 32'(cfg_err), 32'd1);

    // enable drop mid-burst
    do_reset();
    set_cfg(40, 8, 1, 0, 3, 5, 10);
    enable = 1'b1;
    run_until(6, "drop");
    enable = 1'b0;
    psc = 0;
    repeat (30) cyc();
    chk("no_start_after_drop", 32'(psc), 32'd0);
    chk("idle_after_drop", 32'(busy), 32'd0);

    // reset mid-burst then immediate restart
    enable = 1'b1;
    run_until(12, "rst");
    do_reset();
    cyc();
    chk("restart_ps", 32'(ping_start), 32'd1);
    chk("restart_err", 32'(cfg_err), 32'd0);

    // config change in WAIT applies next ping
    run_until(25, "cfg");
    set_cfg(40, 8, 1, 0, 3, 20, 10);
    repeat (90) cyc();

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0)
        set_cfg($urandom_range(0, 45), $urandom_range(0, 10), $urandom_range(0, 3),
                $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
